// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parameterised register file with two combinational read ports, one write
// port, same-cycle write-to-read bypass and a clear sequencer that zeroes the
// storage registers one per clock.
//
// Register 0 is hard-wired to zero and ignores writes; registers
// 1..DEPTH-1 hold WIDTH bits each.
//
// Ports
//   clock     in   1      single clock, all state updates on rising edge
//   reset     in   1      synchronous, active-high reset
//   rr1       in   AW     read-port-1 address
//   rr2       in   AW     read-port-2 address
//   wr        in   AW     write address
//   wd        in   WIDTH  write data
//   regwrite  in   1      write enable
//   clear     in   1      start the clear sequencer
//   rd1       out  WIDTH  read-port-1 data
//   rd2       out  WIDTH  read-port-2 data
//   busy      out  1      high while the clear sequencer runs
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    input  logic [AW-1:0]    wr,
    input  logic [WIDTH-1:0] wd,
    input  logic             regwrite,
    input  logic             clear,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy
);

    // Two-bit encoding so the unused codes exist and are explicitly steered
    // back to IDLE by the next-state logic.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_next;
    logic             in_clear;
    logic             write_en;

    // Storage for registers 1..DEPTH-1 only; register 0 has no flops.
    logic [WIDTH-1:0] regs [1:DEPTH-1];

    assign in_clear = (state == CLEAR);
    assign busy     = in_clear;

    // A write is accepted only from IDLE and never to register 0. The same
    // qualified enable drives the bypass, so a forwarded value is always one
    // that actually commits at the coming edge.
    assign write_en = regwrite && (state == IDLE) && (wr != '0);

    // Clear sequencer next-state logic. ptr starts at 1 because register 0
    // has nothing to clear; the sequence ends on the edge that zeroes the
    // last register, after which ptr simply wraps modulo 2^AW.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    ptr_next   = FIRST_ADDR;
                end
            end
            CLEAR: begin
                ptr_next = ptr + FIRST_ADDR;
                if (ptr == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // State, pointer and storage update. Reset overrides everything,
    // including a sequence already in progress. In CLEAR the write enable is
    // already low, so the clear and write paths never collide.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            for (int i = 1; i < DEPTH; i++) begin
                if (in_clear && (ptr == AW'(i))) begin
                    regs[i] <= '0;
                end else if (write_en && (wr == AW'(i))) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    // Read port 1: address 0 falls through to the zero default, then the
    // bypass overrides the stored value when the write targets this address.
    always_comb begin
        rd1 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rr1 == AW'(i)) begin
                rd1 = regs[i];
            end
        end
        if (write_en && (rr1 == wr)) begin
            rd1 = wd;
        end
    end

    // Read port 2, identical structure to port 1.
    always_comb begin
        rd2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (rr2 == AW'(i)) begin
                rd2 = regs[i];
            end
        end
        if (write_en && (rr2 == wr)) begin
            rd2 = wd;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//
// Drives two register files from one stimulus stream: the default
// 16-bit x 4 configuration and a 32-bit x 8 configuration. The 16-bit
// instance sees the low address and data bits. Each instance is compared
// every cycle against a behavioural model of the register file.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    logic        clock;
    logic        reset;
    logic        regwrite;
    logic        clear;
    logic [2:0]  rr1;
    logic [2:0]  rr2;
    logic [2:0]  wr;
    logic [31:0] wd;

    logic [15:0] rd1_s;
    logic [15:0] rd2_s;
    logic        busy_s;
    logic [31:0] rd1_w;
    logic [31:0] rd2_w;
    logic        busy_w;

    int checks;
    int failures;
    int busy_cnt [2];

    // Behavioural model: contents per instance, plus which register the
    // clear sequence will zero next (0 means no clear in progress).
    logic [31:0] mdl [2][8];
    int          clr_idx [2];

    reg_file_param dut_s (
        .clock    (clock),
        .reset    (reset),
        .rr1      (rr1[1:0]),
        .rr2      (rr2[1:0]),
        .wr       (wr[1:0]),
        .wd       (wd[15:0]),
        .regwrite (regwrite),
        .clear    (clear),
        .rd1      (rd1_s),
        .rd2      (rd2_s),
        .busy     (busy_s)
    );

    reg_file_param #(.WIDTH(32), .DEPTH(8), .AW(3)) dut_w (
        .clock    (clock),
        .reset    (reset),
        .rr1      (rr1),
        .rr2      (rr2),
        .wr       (wr),
        .wd       (wd),
        .regwrite (regwrite),
        .clear    (clear),
        .rd1      (rd1_w),
        .rd2      (rd2_w),
        .busy     (busy_w)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int depth_of(int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic logic [31:0] mask_of(int k);
        return (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic int addr_of(int k, logic [2:0] a);
        return int'(a) % depth_of(k);
    endfunction

    // Expected read data for instance k at address a under the current inputs.
    function automatic logic [31:0] exp_read(int k, logic [2:0] a);
        int ra;
        int wa;
        ra = addr_of(k, a);
        wa = addr_of(k, wr);
        if (ra == 0) return 32'h0;
        if (regwrite && clr_idx[k] == 0 && wa != 0 && wa == ra) return wd & mask_of(k);
        return mdl[k][ra];
    endfunction

    // Advance the model by one rising edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 8; r++) mdl[k][r] = 32'h0;
                clr_idx[k] = 0;
            end else if (clr_idx[k] != 0) begin
                mdl[k][clr_idx[k]] = 32'h0;
                clr_idx[k] = (clr_idx[k] == depth_of(k) - 1) ? 0 : clr_idx[k] + 1;
            end else begin
                if (regwrite && addr_of(k, wr) != 0)
                    mdl[k][addr_of(k, wr)] = wd & mask_of(k);
                if (clear) clr_idx[k] = 1;
            end
        end
    endtask

    task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        checkOutput("rd1_w16", {16'h0, rd1_s}, exp_read(0, rr1));
        checkOutput("rd2_w16", {16'h0, rd2_s}, exp_read(0, rr2));
        checkOutput("busy_w16", {31'h0, busy_s}, {31'h0, clr_idx[0] != 0});
        checkOutput("rd1_w32", rd1_w, exp_read(1, rr1));
        checkOutput("rd2_w32", rd2_w, exp_read(1, rr2));
        checkOutput("busy_w32", {31'h0, busy_w}, {31'h0, clr_idx[1] != 0});
    endtask

    // One clock cycle: drive inputs, check settled outputs before the edge,
    // then let the edge happen and advance the model.
    task automatic applyStimulus(input logic rst, input logic we, input logic clr,
                                 input logic [2:0] wa, input logic [31:0] wdv,
                                 input logic [2:0] a1, input logic [2:0] a2);
        reset    = rst;
        regwrite = we;
        clear    = clr;
        wr       = wa;
        wd       = wdv;
        rr1      = a1;
        rr2      = a2;
        #2;
        check_all();
        if (busy_s) busy_cnt[0]++;
        if (busy_w) busy_cnt[1]++;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_read(input logic [2:0] a1, input logic [2:0] a2);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, a1, a2);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        for (int k = 0; k < 2; k++) begin
            clr_idx[k] = 0;
            for (int r = 0; r < 8; r++) mdl[k][r] = 32'h0;
        end

        // Bring both instances out of power-up before any check.
        reset = 1'b1; regwrite = 1'b0; clear = 1'b0;
        wr = 3'd0; wd = 32'h0; rr1 = 3'd0; rr2 = 3'd0;
        @(posedge clock);
        @(posedge clock);
        #1;

        // All addresses read zero after reset.
        for (int a = 0; a < 8; a++) idle_read(3'(a), 3'(7 - a));

        // Basic write then sweep readback on both ports.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_A5A5, 3'd0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 32'h0000_1234, 3'd0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h0000_FFFF, 3'd0, 3'd0);
        for (int a = 0; a < 4; a++) idle_read(3'(a), 3'(a));
        checkOutput("sweep_r3_w16", {16'h0, rd1_s}, 32'h0000_FFFF);

        // Write to register 0 is dropped and never bypassed.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_BEEF, 3'd0, 3'd0);
        idle_read(3'd0, 3'd0);

        // Same-cycle bypass on port 1, port 2 untouched, then stable readback.
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 32'h0000_5678, 3'd2, 3'd1);
        idle_read(3'd2, 3'd1);
        checkOutput("bypass_commit_w16", {16'h0, rd1_s}, 32'h0000_5678);

        // Fill every register of the wide instance with distinct values.
        for (int a = 1; a < 8; a++)
            applyStimulus(1'b0, 1'b1, 1'b0, 3'(a), 32'hC0DE_0000 + 32'(a * 32'h1111), 3'(a), 3'(a - 1));
        for (int a = 0; a < 8; a++) idle_read(3'(a), 3'(a));

        // Clear pulse: write to r3 in the first busy cycle is dropped,
        // a second clear pulse during busy is ignored.
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 3'd1, 3'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h0000_7777, 3'd3, 3'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 3'd2, 3'd3);
        for (int c = 0; c < 8; c++) idle_read(3'(c), 3'(7 - c));
        checkOutput("busy_len_w16", 32'(busy_cnt[0]), 32'd3);
        checkOutput("busy_len_w32", 32'(busy_cnt[1]), 32'd7);

        // Clear together with a write: the write commits, then gets cleared.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_4444, 3'd3, 3'd2);
        for (int c = 0; c < 8; c++) idle_read(3'd3, 3'(c));

        // Reset on the second cycle of a clear aborts it.
        for (int a = 1; a < 8; a++)
            applyStimulus(1'b0, 1'b1, 1'b0, 3'(a), 32'h0000_9000 + 32'(a), 3'd0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 3'd3, 3'd3);
        idle_read(3'd3, 3'd5);
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_DDDD, 3'd2, 3'd3);
        checkOutput("reset_abort_busy_w32", {31'h0, busy_w}, 32'h0);
        for (int a = 0; a < 8; a++) idle_read(3'(a), 3'(a));
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 32'h0000_0F0F, 3'd3, 3'd0);
        idle_read(3'd3, 3'd3);
        checkOutput("post_reset_write_w16", {16'h0, rd2_s}, 32'h0000_0F0F);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 19) == 0),
                          3'($urandom_range(0, 7)),
                          $urandom(),
                          3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
